// File: rtl/calc_pkg.sv
// Shared types for the round-robin calc scheduler: op codes, FSM states, data width.
package calc_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        OP_ADD3 = 2'b00,
        OP_SUBA = 2'b01,
        OP_SUBB = 2'b10,
        OP_SUBC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above the pointer, wrapping to 0.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW:0]   w_pos_ext;
    logic [IDW-1:0] w_pos;

    always_comb begin
        o_gnt     = '0;
        o_idx     = '0;
        o_any     = 1'b0;
        w_pos_ext = '0;
        w_pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // (ptr + k) mod NREQ without a divider; ptr is always < NREQ
            w_pos_ext = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_pos_ext >= (IDW+1)'(NREQ)) begin
                w_pos_ext = w_pos_ext - (IDW+1)'(NREQ);
            end
            w_pos = w_pos_ext[IDW-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_rr_sched.sv
// Shares one 3-operand calc datapath between NREQ requesters, one op in flight at a time.
// Optional per-requester completion counters enabled by CALC_RR_SCHED_STATS_EN.
module calc_rr_sched
    import calc_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [DW*NREQ-1:0] req_a,
    input  logic [DW*NREQ-1:0] req_b,
    input  logic [DW*NREQ-1:0] req_c,
    input  logic [2*NREQ-1:0]  req_op,
    output logic [DW-1:0]      calc_a,
    output logic [DW-1:0]      calc_b,
    output logic [DW-1:0]      calc_c,
    output logic [1:0]         calc_op,
    input  logic [DW-1:0]      calc_r,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [DW-1:0]      resp_data,
    output logic               busy
`ifdef CALC_RR_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt,
    input  logic               stats_clr
`endif
);

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_ptr;
    logic [DW-1:0]   r_calc_a;
    logic [DW-1:0]   r_calc_b;
    logic [DW-1:0]   r_calc_c;
    op_t             r_calc_op;
    logic [IDW-1:0]  r_resp_id;
    logic [DW-1:0]   r_resp_data;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_take;
    logic            w_done;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Handshake is combinational: ready is the live grant while idle.
    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        w_take     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst ? '0 : w_gnt;
                w_take    = w_any;
                if (w_any) w_next = EXEC;
            end
            EXEC: w_next = RESP;
            RESP: begin
                resp_valid = 1'b1;
                w_done     = resp_ready;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_calc_a    <= '0;
            r_calc_b    <= '0;
            r_calc_c    <= '0;
            r_calc_op   <= OP_ADD3;
            r_resp_id   <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_take) begin
                r_calc_a  <= req_a[DW*w_idx +: DW];
                r_calc_b  <= req_b[DW*w_idx +: DW];
                r_calc_c  <= req_c[DW*w_idx +: DW];
                r_calc_op <= op_t'(req_op[2*w_idx +: 2]);
                r_resp_id <= w_idx;
                r_ptr     <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
            end
            if (r_state == EXEC) begin
                r_resp_data <= calc_r;
            end
        end
    end

    assign calc_a    = r_calc_a;
    assign calc_b    = r_calc_b;
    assign calc_c    = r_calc_c;
    assign calc_op   = r_calc_op;
    assign resp_id   = r_resp_id;
    assign resp_data = r_resp_data;

`ifdef CALC_RR_SCHED_STATS_EN
    logic [15:0] r_cnt [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        // Clear has priority over a coincident completion.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt[gi] <= '0;
            end else if (stats_clr) begin
                r_cnt[gi] <= '0;
            end else if (w_done && (r_resp_id == IDW'(gi)) && (r_cnt[gi] != 16'hFFFF)) begin
                r_cnt[gi] <= r_cnt[gi] + 16'd1;
            end
        end
        assign grant_cnt[16*gi +: 16] = r_cnt[gi];
    end
`endif

endmodule
